// File: rtl/slow_clock_edge_recovery.sv
// slow_clock_edge_recovery
// Samples an external slow serial clock with the fast system clock and
// rebuilds its edge and mid-level strobes. It also measures the high and
// low times of the recovered clock and reports lock once the period is stable.
module slow_clock_edge_recovery #(
  parameter int COUNTER_BITS = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_COUNT   = 4,
  parameter int TOLERANCE    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ext_clk,
  output logic                    recovered_clk,
  output logic                    rising_edge,
  output logic                    falling_edge,
  output logic                    middle_of_high_level,
  output logic                    middle_of_low_level,
  output logic                    locked,
  output logic                    timeout,
  output logic [COUNTER_BITS-1:0] high_time,
  output logic [COUNTER_BITS-1:0] low_time
);

  localparam int CB = COUNTER_BITS;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CB-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_TRAINING,
    ST_LOCKED
  } state_t;

  state_t          state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            sync_last;
  logic            edge_det;
  logic [CB-1:0]   level_cnt;
  logic            timeout_hit;
  logic            fall_seen;
  logic [CB:0]     period;
  logic [CB:0]     ref_period, ref_next;
  logic            ref_valid, ref_valid_next;
  logic [CB:0]     period_diff;
  logic            in_tol;
  logic [MW-1:0]   match_cnt, match_next;
  logic            locked_next;

  assign sync_last = sync_q[SYNC_STAGES-1];
  // A level change has reached the end of the synchroniser but not the output yet.
  assign edge_det  = sync_last ^ recovered_clk;
  // The counter is about to saturate (or already has) with no edge in sight.
  assign timeout_hit = ~edge_det & (level_cnt >= (CNT_MAX - CB'(1)));

  // Metastability chain: ext_clk enters bit 0 and shifts towards the top bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], ext_clk};
  end

  // Recovered clock and its edge pulses change on the same clk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      recovered_clk <= 1'b0;
      rising_edge   <= 1'b0;
      falling_edge  <= 1'b0;
    end else begin
      recovered_clk <= sync_last;
      rising_edge   <= sync_last & ~recovered_clk;
      falling_edge  <= ~sync_last & recovered_clk;
    end
  end

  // Level length counter: restarts at 1 on each edge, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                   level_cnt <= '0;
    else if (edge_det)           level_cnt <= CB'(1);
    else if (level_cnt != CNT_MAX) level_cnt <= level_cnt + CB'(1);
  end

  // Capture the length of the level that is ending, and track timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_time <= '0;
      low_time  <= '0;
      timeout   <= 1'b0;
    end else begin
      if (edge_det && !sync_last) high_time <= level_cnt;
      if (edge_det && sync_last)  low_time  <= level_cnt;
      if (edge_det)               timeout   <= 1'b0;
      else if (timeout_hit)       timeout   <= 1'b1;
    end
  end

  // Remembers whether a full high level preceded the current rising edge.
  always_ff @(posedge clk) begin
    if (reset)             fall_seen <= 1'b0;
    else if (falling_edge) fall_seen <= 1'b1;
    else if (rising_edge)  fall_seen <= 1'b0;
  end

  // low_time is freshly captured in the rising_edge cycle, so the sum is the full period.
  assign period      = {1'b0, high_time} + {1'b0, low_time};
  assign period_diff = (period >= ref_period) ? (period - ref_period) : (ref_period - period);
  assign in_tol      = (period_diff <= (CB+1)'(TOLERANCE));

  // Midpoint strobes use the previous level's length; only meaningful when locked.
  assign middle_of_high_level = recovered_clk & locked & (high_time >= CB'(2)) &
                                (level_cnt == (high_time >> 1));
  assign middle_of_low_level  = ~recovered_clk & locked & (low_time >= CB'(2)) &
                                (level_cnt == (low_time >> 1));

  // Lock FSM state and its bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_UNLOCKED;
      ref_period <= '0;
      ref_valid  <= 1'b0;
      match_cnt  <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_next;
      ref_period <= ref_next;
      ref_valid  <= ref_valid_next;
      match_cnt  <= match_next;
      locked     <= locked_next;
    end
  end

  // Lock FSM next state: evaluated on the rising_edge pulse, so locked moves one cycle later.
  // A rising edge and counter saturation cannot coincide; the edge is listed first.
  always_comb begin
    state_next     = state;
    ref_next       = ref_period;
    ref_valid_next = ref_valid;
    match_next     = match_cnt;
    locked_next    = locked;
    if (rising_edge) begin
      case (state)
        ST_UNLOCKED: begin
          state_next     = ST_TRAINING;
          ref_valid_next = 1'b0;
          match_next     = '0;
        end
        ST_TRAINING: begin
          if (!fall_seen) begin
            state_next     = ST_UNLOCKED;
            ref_valid_next = 1'b0;
            match_next     = '0;
          end else if (!ref_valid) begin
            ref_next       = period;
            ref_valid_next = 1'b1;
          end else if (in_tol) begin
            match_next = match_cnt + MW'(1);
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_next  = ST_LOCKED;
              locked_next = 1'b1;
            end
          end else begin
            ref_next   = period;
            match_next = '0;
          end
        end
        ST_LOCKED: begin
          if (fall_seen && in_tol) begin
            ref_next = period;
          end else begin
            state_next     = ST_UNLOCKED;
            locked_next    = 1'b0;
            ref_valid_next = 1'b0;
            match_next     = '0;
          end
        end
        default: begin
          state_next     = ST_UNLOCKED;
          locked_next    = 1'b0;
          ref_valid_next = 1'b0;
          match_next     = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_next     = ST_UNLOCKED;
      locked_next    = 1'b0;
      ref_valid_next = 1'b0;
      match_next     = '0;
    end
  end

endmodule
